lsu_mem_ctrl: RTL
=================

// Module: lsu_mem_ctrl
// PURPOSE
//  Load/store unit in the MEM/WB stage. Responds to the decoder's memory
//  controls (rd_en, wr_en, mem_type) by running one word-wide bus
//  transaction per access. Generates byte strobes, replicates store data
//  and sign/zero-extends load data. Stalls the pipeline until the bus
//  transaction completes.
// PARAMETERS
//  TIMEOUT  255  max cycles in REQ+WAIT before abort (1..255, 8-bit counter)
// PORTS
//  clk         in   1   clock, all state updates on rising edge
//  rst         in   1   synchronous, active-high reset
//  rd_en       in   1   load request, level; held stable while stall=1
//  wr_en       in   1   store request, level; wins over rd_en if both set
//  mem_type    in   3   st: 000 SB,001 SH,010 SW; ld: 000 LB,001 LH,010 LW,011 LBU,100 LHU
//  addr        in   32  byte address from ALU
//  wdata       in   32  store data (rs2)
//  rdata       out  32  extended load result; valid in DONE, then held
//  stall       out  1   freeze PC/pipeline registers
//  misaligned  out  1   combinational trap flag for a misaligned access
//  bus_err     out  1   one-cycle pulse in DONE after timeout
//  bus_req     out  1   bus request, held until bus_gnt
//  bus_we      out  1   1 = write
//  bus_addr    out  32  {addr[31:2],2'b00}
//  bus_wdata   out  32  replicated store data
//  bus_strb    out  4   byte enables, all 0 on reads
//  bus_gnt     in   1   request accepted (write complete)
//  bus_rvalid  in   1   read data valid, any cycle >= 1 after gnt
//  bus_rdata   in   32  read word
// BEHAVIOUR
//  Reset: state=IDLE; rdata, bus_* outputs, bus_err, timeout counter all 0.
//  FSM states and transitions:
//   IDLE: access=(rd_en|wr_en)&~misaligned. If access, latch the inputs
//         and go to REQ.
//   REQ:  bus_req=1 with latched fields. On bus_gnt: a store goes to
//         DONE, a load goes to WAIT.
//   WAIT: on bus_rvalid, rdata<=extend(bus_rdata) and go to DONE.
//   DONE: one cycle with stall=0, then back to IDLE.
//  stall = (IDLE & access) | REQ | WAIT. Combinational: an access raises
//   stall in its first cycle.
//  Latency: store = 3 cycles minimum (IDLE,REQ,DONE) with gnt in its first
//   REQ cycle. Load = 4 cycles minimum.
//  misaligned (IDLE only): SH/LH/LHU with addr[0]=1; SW/LW with addr[1:0]!=0.
//   No bus activity and no stall; rdata is unchanged.
//  Store strobes and data:
//   SB: strb=4'b0001<<addr[1:0]; wdata={4{wdata[7:0]}}
//   SH: strb=addr[1]?4'b1100:4'b0011; wdata={2{wdata[15:0]}}
//   SW: strb=4'b1111
//  Load extend: the byte or half is selected by the latched addr[1:0].
//   LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
//  Undefined mem_type: treated as word width; a load is zero-extended.
//  Timeout: counter clears on entering REQ and counts in REQ/WAIT. At
//   TIMEOUT it goes to DONE with bus_err=1; a load sets rdata=0.
//  bus_rvalid outside WAIT and bus_gnt outside REQ are ignored.
//  rst in any state returns to IDLE next edge with bus_req=0; no retry.
// TESTING
//  1 SW addr=0x100 wdata=0xDEADBEEF, gnt in 1st REQ -> strb=1111,
//    bus_addr=0x100, stall high 2 cycles.
//  2 LB addr=0x103, bus_rdata=0x80FF_FFFF -> rdata=0xFFFFFF80;
//    LBU same -> 0x00000080.
//  3 SH addr=0x102 wdata=0x1234 -> strb=1100, bus_wdata=0x12341234;
//    LHU addr=0x102, rdata word 0xBEEF0000 -> rdata=0x0000BEEF.
//  4 LW addr=0x101 -> misaligned=1, stall=0, bus_req never asserts.
//  5 LW, gnt delayed 3 cycles and rvalid 2 later -> stall held throughout,
//    drops exactly in DONE.
//  6 No rvalid for TIMEOUT cycles -> bus_err one cycle, rdata=0, then IDLE.
//    Also: rst in WAIT -> IDLE next cycle, all outputs 0.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit for the MEM/WB stage: one word-wide bus transaction per access,
// with byte strobes, store-data replication, load extension and a transaction timeout.
module lsu_mem_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [2:0]  mem_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_strb,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic [2:0]       ld_type;
  logic [1:0]       ld_off;

  logic        is_byte;
  logic        is_half;
  logic        req_in;
  logic        mis_c;
  logic        access;
  logic        timeout;
  logic        load_done;
  logic [3:0]  strb_in;
  logic [31:0] wdata_in;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext;

  // Access width from the decoder; undefined encodings fall back to word width.
  assign is_byte = (mem_type == 3'b000) || (!wr_en && mem_type == 3'b011);
  assign is_half = (mem_type == 3'b001) || (!wr_en && mem_type == 3'b100);
  assign req_in  = rd_en | wr_en;

  always_comb begin
    mis_c = 1'b0;
    if (is_half)       mis_c = addr[0];
    else if (!is_byte) mis_c = (addr[1:0] != 2'b00);
  end

  assign access     = req_in && !mis_c;
  assign misaligned = (state == S_IDLE) && req_in && mis_c;
  assign stall      = ((state == S_IDLE) && access) || (state == S_REQ) || (state == S_WAIT);

  // Store byte lanes and replicated data; reads drive no strobes.
  always_comb begin
    strb_in  = 4'b1111;
    wdata_in = wdata;
    if (is_byte) begin
      strb_in  = 4'b0001 << addr[1:0];
      wdata_in = {4{wdata[7:0]}};
    end else if (is_half) begin
      strb_in  = addr[1] ? 4'b1100 : 4'b0011;
      wdata_in = {2{wdata[15:0]}};
    end
    if (!wr_en) begin
      strb_in  = 4'b0000;
      wdata_in = 32'h0;
    end
  end

  // Load extension using the latched type and byte offset.
  always_comb begin
    byte_sel = bus_rdata[{ld_off, 3'b000} +: 8];
    half_sel = ld_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (ld_type)
      3'b000:  ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ext = {{16{half_sel[15]}}, half_sel};
      3'b011:  ext = {24'h0, byte_sel};
      3'b100:  ext = {16'h0, half_sel};
      default: ext = bus_rdata;
    endcase
  end

  // Next state; a completing gnt/rvalid beats the timeout in the same cycle,
  // but a load granted on its last allowed cycle has no room left to wait.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    timeout   = 1'b0;
    load_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (access) begin
          state_d = S_REQ;
          cnt_d   = '0;
        end
      end
      S_REQ: begin
        cnt_d = cnt + CNT_W'(1);
        if (bus_gnt && bus_we) begin
          state_d = S_DONE;
        end else if (cnt == CNT_LAST) begin
          state_d = S_DONE;
          timeout = 1'b1;
        end else if (bus_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt + CNT_W'(1);
        if (bus_rvalid) begin
          state_d   = S_DONE;
          load_done = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_d = S_DONE;
          timeout = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ld_type   <= 3'b000;
      ld_off    <= 2'b00;
      rdata     <= 32'h0;
      bus_err   <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_wdata <= 32'h0;
      bus_strb  <= 4'b0000;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bus_req <= (state_d == S_REQ);
      bus_err <= timeout;
      if ((state == S_IDLE) && access) begin
        bus_we    <= wr_en;
        bus_addr  <= {addr[31:2], 2'b00};
        bus_wdata <= wdata_in;
        bus_strb  <= strb_in;
        ld_type   <= mem_type;
        ld_off    <= addr[1:0];
      end
      if (load_done)                rdata <= ext;
      else if (timeout && !bus_we)  rdata <= 32'h0;
    end
  end

endmodule
